// File: rtl/code_defs_pkg.sv
// Shared 64b/66b definitions: XGMII characters, 10GBASE-R control codes,
// block types, sync headers and the transmit FSM / block class enums.
package code_defs_pkg;

    localparam logic [7:0] RS_IDLE  = 8'h07;
    localparam logic [7:0] RS_START = 8'hFB;
    localparam logic [7:0] RS_TERM  = 8'hFD;
    localparam logic [7:0] RS_SEQ   = 8'h9C;
    localparam logic [7:0] RS_SIG   = 8'h5C;

    localparam logic [6:0] CC_ERROR = 7'h1E;
    localparam logic [3:0] OC_SEQ   = 4'h0;
    localparam logic [3:0] OC_SIG   = 4'hF;

    localparam logic [7:0] BT_IDLE  = 8'h1E;
    localparam logic [7:0] BT_O4    = 8'h2D;
    localparam logic [7:0] BT_S4    = 8'h33;
    localparam logic [7:0] BT_O0S4  = 8'h66;
    localparam logic [7:0] BT_O0O4  = 8'h55;
    localparam logic [7:0] BT_S0    = 8'h78;
    localparam logic [7:0] BT_O0    = 8'h4B;

    localparam logic [1:0] SYNC_DATA = 2'b01;
    localparam logic [1:0] SYNC_CTL  = 2'b10;

    localparam logic [63:0] E_BLOCK = {{8{CC_ERROR}}, BT_IDLE};

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        BLK_C = 3'd0,
        BLK_S = 3'd1,
        BLK_D = 3'd2,
        BLK_T = 3'd3,
        BLK_E = 3'd4
    } blk_class_t;

    function automatic logic [7:0] t_type(input int unsigned n);
        case (n)
            0:       t_type = 8'h87;
            1:       t_type = 8'h99;
            2:       t_type = 8'hAA;
            3:       t_type = 8'hB4;
            4:       t_type = 8'hCC;
            5:       t_type = 8'hD2;
            6:       t_type = 8'hE1;
            default: t_type = 8'hFF;
        endcase
    endfunction

    // Mask of lanes strictly below lane n (n may be 8).
    function automatic logic [7:0] lanes_below(input int unsigned n);
        logic [15:0] m;
        m = (16'd1 << n) - 16'd1;
        return m[7:0];
    endfunction

endpackage

// File: rtl/encode_6466b_core.sv
// Combinational 64b/66b block encoder: one 64-bit XGMII block in,
// payload + sync header + block class out.
module encode_6466b_core
    import code_defs_pkg::*;
(
    input  logic [63:0] i_data,
    input  logic [7:0]  i_ctl,
    output logic [63:0] o_payload,
    output logic [1:0]  o_header,
    output blk_class_t  o_class
);

    logic [7:0] idle, ord, start, term;
    logic [3:0] o0, o4;

    always_comb begin
        idle  = '0;
        ord   = '0;
        start = '0;
        term  = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idle[i]  = i_ctl[i] && (i_data[8*i +: 8] == RS_IDLE);
            ord[i]   = i_ctl[i] && (i_data[8*i +: 8] == RS_SEQ || i_data[8*i +: 8] == RS_SIG);
            start[i] = i_ctl[i] && (i_data[8*i +: 8] == RS_START);
            term[i]  = i_ctl[i] && (i_data[8*i +: 8] == RS_TERM);
        end
        o0 = (i_data[7:0]   == RS_SIG) ? OC_SIG : OC_SEQ;
        o4 = (i_data[39:32] == RS_SIG) ? OC_SIG : OC_SEQ;
    end

    // Idle lanes always encode to control code 0, so they appear as zero fill.
    always_comb begin
        o_payload = E_BLOCK;
        o_header  = SYNC_CTL;
        o_class   = BLK_E;
        if (i_ctl == '0) begin
            o_payload = i_data;
            o_header  = SYNC_DATA;
            o_class   = BLK_D;
        end else if (idle == '1) begin
            o_payload = {56'h0, BT_IDLE};
            o_class   = BLK_C;
        end else if (idle[3:0] == '1 && ord[4] && i_ctl[7:5] == '0) begin
            o_payload = {i_data[63:40], o4, 28'h0, BT_O4};
            o_class   = BLK_C;
        end else if (idle[3:0] == '1 && start[4] && i_ctl[7:5] == '0) begin
            o_payload = {i_data[63:40], 4'h0, 28'h0, BT_S4};
            o_class   = BLK_S;
        end else if (ord[0] && i_ctl[3:1] == '0 && start[4] && i_ctl[7:5] == '0) begin
            o_payload = {i_data[63:40], 4'h0, o0, i_data[31:8], BT_O0S4};
            o_class   = BLK_S;
        end else if (ord[0] && i_ctl[3:1] == '0 && ord[4] && i_ctl[7:5] == '0) begin
            o_payload = {i_data[63:40], o4, o0, i_data[31:8], BT_O0O4};
            o_class   = BLK_C;
        end else if (start[0] && i_ctl[7:1] == '0) begin
            o_payload = {i_data[63:8], BT_S0};
            o_class   = BLK_S;
        end else if (ord[0] && i_ctl[3:1] == '0 && idle[7:4] == '1) begin
            o_payload = {28'h0, o0, i_data[31:8], BT_O0};
            o_class   = BLK_C;
        end else begin
            for (int unsigned n = 0; n < 8; n++) begin
                if (term[n] && (i_ctl & lanes_below(n)) == '0
                    && (~idle & ~lanes_below(n + 1)) == '0) begin
                    o_payload = ((i_data & ((64'h1 << (8*n)) - 64'h1)) << 8) | {56'h0, t_type(n)};
                    o_class   = BLK_T;
                end
            end
        end
    end

endmodule

// File: rtl/encode_6466b_fsm.sv
// 64b/66b PCS transmit encoder: beat assembly, clause-49 transmit FSM,
// saturating illegal-block counter and beat-serialised output.
module encode_6466b_fsm
    import code_defs_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ERR_CNT_WIDTH = 16
) (
    input  logic                      i_txc,
    input  logic                      i_reset,
    input  logic                      i_init_done,
    input  logic [DATA_WIDTH-1:0]     i_txd,
    input  logic [DATA_WIDTH/8-1:0]   i_txctl,
    input  logic                      i_tx_pause,
    input  logic                      i_err_clear,
    output logic [DATA_WIDTH-1:0]     o_txd,
    output logic [1:0]                o_tx_header,
    output logic [2:0]                o_tx_state,
    output logic [ERR_CNT_WIDTH-1:0]  o_err_count
);

    localparam int unsigned DATA_NBYTES = DATA_WIDTH / 8;
    localparam int unsigned NBEATS      = 64 / DATA_WIDTH;
    localparam int unsigned BEAT_W      = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    if (DATA_WIDTH != 16 && DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
        $error("encode_6466b_fsm: DATA_WIDTH must be 16, 32 or 64");
    end

    logic [BEAT_W-1:0] beat;
    logic [31:0]       beat_ofs, beat_cofs;
    logic              adv, last, done;
    logic [63:0]       blk_d, enc_pl, out_blk;
    logic [7:0]        blk_c;
    logic [1:0]        enc_hdr, out_hdr;
    blk_class_t        enc_cls;
    tx_state_t         state, nxt;
    logic              bump;

    assign adv       = !i_tx_pause;
    assign last      = (beat == LAST_BEAT);
    assign done      = adv && last;
    assign beat_ofs  = 32'(beat) * DATA_WIDTH;
    assign beat_cofs = 32'(beat) * DATA_NBYTES;

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset)  beat <= '0;
        else if (adv) beat <= last ? '0 : beat + BEAT_W'(1);
    end

    if (NBEATS > 1) begin : g_stage
        localparam int unsigned SW = 64 - DATA_WIDTH;
        localparam int unsigned SC = 8 - DATA_NBYTES;
        logic [SW-1:0] stage_d;
        logic [SC-1:0] stage_c;

        always_ff @(posedge i_txc or posedge i_reset) begin
            if (i_reset) begin
                stage_d <= '0;
                stage_c <= '0;
            end else if (adv && !last) begin
                stage_d[beat_ofs +: DATA_WIDTH]   <= i_txd;
                stage_c[beat_cofs +: DATA_NBYTES] <= i_txctl;
            end
        end

        assign blk_d = {i_txd, stage_d};
        assign blk_c = {i_txctl, stage_c};
    end else begin : g_nostage
        assign blk_d = i_txd;
        assign blk_c = i_txctl;
    end

    encode_6466b_core u_core (
        .i_data    (blk_d),
        .i_ctl     (blk_c),
        .o_payload (enc_pl),
        .o_header  (enc_hdr),
        .o_class   (enc_cls)
    );

    always_comb begin
        nxt = TX_E;
        case (state)
            TX_INIT, TX_C, TX_T: begin
                if (enc_cls == BLK_C)      nxt = TX_C;
                else if (enc_cls == BLK_S) nxt = TX_D;
            end
            TX_D: begin
                if (enc_cls == BLK_D)      nxt = TX_D;
                else if (enc_cls == BLK_T) nxt = TX_T;
            end
            TX_E: begin
                case (enc_cls)
                    BLK_D:   nxt = TX_D;
                    BLK_T:   nxt = TX_T;
                    BLK_C:   nxt = TX_C;
                    BLK_S:   nxt = TX_D;
                    default: nxt = TX_E;
                endcase
            end
            default: nxt = TX_E;
        endcase
    end

    // Output block only changes at block boundaries so the header stays stable.
    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            state   <= TX_INIT;
            out_blk <= E_BLOCK;
            out_hdr <= SYNC_CTL;
        end else if (done) begin
            if (!i_init_done) begin
                state   <= TX_INIT;
                out_blk <= E_BLOCK;
                out_hdr <= SYNC_CTL;
            end else if (nxt == TX_E) begin
                state   <= TX_E;
                out_blk <= E_BLOCK;
                out_hdr <= SYNC_CTL;
            end else begin
                state   <= nxt;
                out_blk <= enc_pl;
                out_hdr <= enc_hdr;
            end
        end
    end

    assign bump = done && i_init_done && (nxt == TX_E);

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset)                    o_err_count <= '0;
        else if (i_err_clear)           o_err_count <= '0;
        else if (bump && o_err_count != '1) o_err_count <= o_err_count + ERR_CNT_WIDTH'(1);
    end

    assign o_txd       = out_blk[beat_ofs +: DATA_WIDTH];
    assign o_tx_header = out_hdr;
    assign o_tx_state  = state;

endmodule

// File: tb/tb_encode_6466b_fsm.sv
// Directed scoreboard bench for encode_6466b_fsm at 32-bit and 16-bit widths.
module tb_encode_6466b_fsm;
    import code_defs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        init32, pause32, clr32;
    logic [31:0] txd32, o_txd32;
    logic [3:0]  ctl32;
    logic [1:0]  o_hdr32, o_cnt32;
    logic [2:0]  o_st32;

    logic        init16, pause16, clr16;
    logic [15:0] txd16, o_txd16, o_cnt16;
    logic [1:0]  ctl16, o_hdr16;
    logic [2:0]  o_st16;

    encode_6466b_fsm #(.DATA_WIDTH(32), .ERR_CNT_WIDTH(2)) dut (
        .i_txc(clk), .i_reset(rst), .i_init_done(init32), .i_txd(txd32), .i_txctl(ctl32),
        .i_tx_pause(pause32), .i_err_clear(clr32), .o_txd(o_txd32), .o_tx_header(o_hdr32),
        .o_tx_state(o_st32), .o_err_count(o_cnt32)
    );

    encode_6466b_fsm #(.DATA_WIDTH(16), .ERR_CNT_WIDTH(16)) dut16 (
        .i_txc(clk), .i_reset(rst), .i_init_done(init16), .i_txd(txd16), .i_txctl(ctl16),
        .i_tx_pause(pause16), .i_err_clear(clr16), .o_txd(o_txd16), .o_tx_header(o_hdr16),
        .o_tx_state(o_st16), .o_err_count(o_cnt16)
    );

    typedef struct packed {
        logic [63:0] pl;
        logic [1:0]  hdr;
        logic [2:0]  st;
        logic [15:0] cnt;
    } exp_t;

    exp_t q32[$];
    exp_t q16[$];
    exp_t cur32, cur16;
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] EBLK     = {{8{7'h1E}}, 8'h1E};
    localparam logic [63:0] IDLE_D   = 64'h0707070707070707;
    localparam logic [63:0] IDLE_PL  = 64'h000000000000001E;
    localparam logic [63:0] S0_D     = 64'h55555555555555FB;
    localparam logic [63:0] S0_PL    = 64'h5555555555555578;
    localparam logic [63:0] DAT_D    = 64'hDEADBEEF01234567;
    localparam logic [63:0] T0_D     = 64'h07070707070707FD;
    localparam logic [63:0] T0_PL    = 64'h0000000000000087;
    localparam logic [63:0] S4_D     = 64'hA3A2A1FB07070707;
    localparam logic [63:0] S4_PL    = 64'hA3A2A10000000033;
    localparam logic [63:0] T5_D     = 64'h0707FD4433221100;
    localparam logic [63:0] T5_PL    = 64'h00004433221100D2;
    localparam logic [63:0] O4_D     = 64'h0302019C07070707;
    localparam logic [63:0] O4_PL    = 64'h030201000000002D;
    localparam logic [63:0] ERR_D    = 64'hFEFEFEFEFEFEFEFE;

    function automatic exp_t mk(input logic [63:0] pl, input logic [1:0] hdr,
                                input tx_state_t st, input int unsigned cnt);
        exp_t e;
        e.pl  = pl;
        e.hdr = hdr;
        e.st  = st;
        e.cnt = cnt[15:0];
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic out32(input int k);
        chk("txd32",   {32'h0, o_txd32}, {32'h0, cur32.pl[32*k +: 32]});
        chk("hdr32",   {62'h0, o_hdr32}, {62'h0, cur32.hdr});
        chk("state32", {61'h0, o_st32},  {61'h0, cur32.st});
        chk("cnt32",   {62'h0, o_cnt32}, {48'h0, cur32.cnt});
    endtask

    task automatic out16(input int k);
        chk("txd16",   {48'h0, o_txd16}, {48'h0, cur16.pl[16*k +: 16]});
        chk("hdr16",   {62'h0, o_hdr16}, {62'h0, cur16.hdr});
        chk("state16", {61'h0, o_st16},  {61'h0, cur16.st});
        chk("cnt16",   {48'h0, o_cnt16}, {48'h0, cur16.cnt});
    endtask

    // Called at a falling edge; checks the previous block while driving this one.
    task automatic send32(input logic [63:0] d, input logic [7:0] c, input exp_t e, input logic clr);
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                if (q32.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL sb32 observed=empty expected=entry");
                end else cur32 = q32.pop_front();
            end
            out32(k);
            txd32 = d[32*k +: 32];
            ctl32 = c[4*k +: 4];
            clr32 = clr & (k == 1);
            @(negedge clk);
        end
        clr32 = 1'b0;
        q32.push_back(e);
    endtask

    task automatic send16(input logic [63:0] d, input logic [7:0] c, input int pb, input exp_t e);
        for (int k = 0; k < 4; k++) begin
            if (k == 0) begin
                if (q16.size() == 0) begin
                    checks++; errors++;
                    $error("FAIL sb16 observed=empty expected=entry");
                end else cur16 = q16.pop_front();
            end
            out16(k);
            txd16 = d[16*k +: 16];
            ctl16 = c[2*k +: 2];
            if (k == pb) begin
                pause16 = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    out16(k);
                end
                pause16 = 1'b0;
            end
            @(negedge clk);
        end
        q16.push_back(e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        q32.delete();
        q16.delete();
        q32.push_back(mk(EBLK, SYNC_CTL, TX_INIT, 0));
        q16.push_back(mk(EBLK, SYNC_CTL, TX_INIT, 0));
    endtask

    initial begin
        #100000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        init32 = 1'b1; pause32 = 1'b0; clr32 = 1'b0; txd32 = IDLE_D[31:0]; ctl32 = '1;
        init16 = 1'b1; pause16 = 1'b0; clr16 = 1'b0; txd16 = IDLE_D[15:0]; ctl16 = '1;
        do_reset();

        // Idle stream, then a frame and other legal block types.
        repeat (4) send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 0), 1'b0);
        send32(S0_D, 8'h01, mk(S0_PL, SYNC_CTL, TX_D, 0), 1'b0);
        repeat (2) send32(DAT_D, 8'h00, mk(DAT_D, SYNC_DATA, TX_D, 0), 1'b0);
        send32(T0_D, 8'hFF, mk(T0_PL, SYNC_CTL, TX_T, 0), 1'b0);
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 0), 1'b0);
        send32(S4_D, 8'h1F, mk(S4_PL, SYNC_CTL, TX_D, 0), 1'b0);
        send32(T5_D, 8'hE0, mk(T5_PL, SYNC_CTL, TX_T, 0), 1'b0);
        send32(O4_D, 8'h1F, mk(O4_PL, SYNC_CTL, TX_C, 0), 1'b0);

        // Data while idle is illegal; idle recovers.
        send32(DAT_D, 8'h00, mk(EBLK, SYNC_CTL, TX_E, 1), 1'b0);
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 1), 1'b0);

        // Counter clear, E->E increments, saturation, clear beats increment.
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 0), 1'b1);
        for (int unsigned i = 1; i <= 5; i++)
            send32(ERR_D, 8'hFF, mk(EBLK, SYNC_CTL, TX_E, (i > 3) ? 3 : i), 1'b0);
        send32(ERR_D, 8'hFF, mk(EBLK, SYNC_CTL, TX_E, 0), 1'b1);
        send32(DAT_D, 8'h00, mk(DAT_D, SYNC_DATA, TX_D, 0), 1'b0);
        send32(T0_D, 8'hFF, mk(T0_PL, SYNC_CTL, TX_T, 0), 1'b0);
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 0), 1'b0);
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 0), 1'b0);

        // 16-bit instance with pauses mid-block and on the final beat.
        do_reset();
        send16(IDLE_D, 8'hFF, -1, mk(IDLE_PL, SYNC_CTL, TX_C, 0));
        send16(S0_D, 8'h01, -1, mk(S0_PL, SYNC_CTL, TX_D, 0));
        send16(DAT_D, 8'h00, 2, mk(DAT_D, SYNC_DATA, TX_D, 0));
        send16(T0_D, 8'hFF, 3, mk(T0_PL, SYNC_CTL, TX_T, 0));
        send16(IDLE_D, 8'hFF, -1, mk(IDLE_PL, SYNC_CTL, TX_C, 0));
        send16(IDLE_D, 8'hFF, -1, mk(IDLE_PL, SYNC_CTL, TX_C, 0));

        // Asynchronous reset mid-frame, then release with init not done.
        txd32 = S0_D[31:0];
        ctl32 = 4'h1;
        @(negedge clk);
        txd32 = S0_D[63:32];
        ctl32 = 4'h0;
        #2 rst = 1'b1;
        #1;
        chk("rst_txd",   {32'h0, o_txd32}, {32'h0, EBLK[31:0]});
        chk("rst_hdr",   {62'h0, o_hdr32}, {62'h0, SYNC_CTL});
        chk("rst_state", {61'h0, o_st32},  {61'h0, TX_INIT});
        chk("rst_cnt",   {62'h0, o_cnt32}, 64'h0);
        init32 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q32.delete();
        q32.push_back(mk(EBLK, SYNC_CTL, TX_INIT, 0));
        send32(IDLE_D, 8'hFF, mk(EBLK, SYNC_CTL, TX_INIT, 0), 1'b0);
        send32(DAT_D, 8'h00, mk(EBLK, SYNC_CTL, TX_INIT, 0), 1'b0);
        send32(ERR_D, 8'hFF, mk(EBLK, SYNC_CTL, TX_INIT, 0), 1'b0);
        init32 = 1'b1;
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 0), 1'b0);
        send32(DAT_D, 8'h00, mk(EBLK, SYNC_CTL, TX_E, 1), 1'b0);
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 1), 1'b0);
        send32(IDLE_D, 8'hFF, mk(IDLE_PL, SYNC_CTL, TX_C, 1), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
